noc_output_port_queue: RTL and testbench



---
 rtl/noc_output_port_queue.sv | 147 ++++++++++++++
 tb/tb_noc_output_port_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port_queue.sv
// noc_output_port_queue
// Router output-port arbiter. Several input channels share one FIFO of DEPTH
// flits. Each cycle the arbiter accepts as many flits as there is free space,
// walking the channels in round-robin order. It drains one flit per cycle
// toward the neighbouring router.
//
// Handshake (valid/ready, both sides): a flit moves on a rising clock edge
// exactly when valid and ready are both high in that cycle. A producer holds
// valid and data stable until that happens. The in_ready grants depend
// combinationally on in_valid, but in_valid never depends on in_ready.
//
// Optional feature: define OUTPUT_QUEUE_STALL_CNT_EN to build a saturating
// 16-bit counter of cycles in which some valid channel was refused.
// Without the macro, stall_count is tied to zero.
module noc_output_port_queue #(
   parameter int NUM_IN = 5,
   parameter int DEPTH  = 8,
   parameter int DEST_W = 8,
   parameter int REQ_W  = 4,
   parameter int DATA_W = 32,
   parameter int FLIT_W = DEST_W + REQ_W + 2 + DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_IN-1:0]          in_valid,
   input  logic [NUM_IN*FLIT_W-1:0]   in_flit,
   output logic [NUM_IN-1:0]          in_ready,
   output logic                       out_valid,
   output logic [FLIT_W-1:0]          out_flit,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic [15:0]                stall_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic [CNT_W-1:0] DEPTH_L  = CNT_W'(DEPTH);
   localparam logic [IDX_W:0]   NUM_IN_L = (IDX_W+1)'(NUM_IN);

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [CNT_W-1:0]  free;
   logic [CNT_W-1:0]  g_cnt;
   logic [NUM_IN-1:0] grant;
   logic [CNT_W-1:0]  slot [NUM_IN];
   logic              deny_seen;
   logic [IDX_W:0]    idx_sum;
   logic [IDX_W-1:0]  idx;
   logic              pop;

   // Free space comes only from the registered count, so a slot freed by
   // this cycle's pop cannot be reused until the next cycle.
   assign free = DEPTH_L - count_q;

   // Round-robin grant walk. Each granted channel gets a write-slot offset
   // in walk order. The first refused valid channel becomes next cycle's
   // top priority.
   always_comb begin
      grant     = '0;
      g_cnt     = '0;
      deny_seen = 1'b0;
      rr_ptr_d  = rr_ptr_q;
      idx_sum   = '0;
      idx       = '0;
      for (int k = 0; k < NUM_IN; k++) slot[k] = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (idx_sum >= NUM_IN_L) idx_sum = idx_sum - NUM_IN_L;
         idx = idx_sum[IDX_W-1:0];
         if (!reset && in_valid[idx]) begin
            if (g_cnt < free) begin
               grant[idx] = 1'b1;
               slot[idx]  = g_cnt;
               g_cnt      = g_cnt + 1'b1;
            end else if (!deny_seen) begin
               deny_seen = 1'b1;
               rr_ptr_d  = idx;
            end
         end
      end
   end

   assign in_ready = grant;

   // Pop and next-state pointer arithmetic. The power-of-two depth makes
   // the pointers wrap naturally.
   always_comb begin
      pop      = !reset && (count_q != '0) && out_ready;
      wr_ptr_d = wr_ptr_q + g_cnt[PTR_W-1:0];
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + g_cnt - CNT_W'(pop);
   end

   // Control state register, with a synchronous reset that discards the
   // FIFO contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Flit storage. Granted flits land in consecutive slots after wr_ptr.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant[i]) mem_q[wr_ptr_q + slot[i][PTR_W-1:0]] <= in_flit[i*FLIT_W +: FLIT_W];
      end
   end

   assign out_valid = (count_q != '0);
   assign out_flit  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;
   assign full      = (count_q == DEPTH_L);
   assign empty     = (count_q == '0);

`ifdef OUTPUT_QUEUE_STALL_CNT_EN
   logic [15:0] stall_q;

   // Count cycles in which some valid channel was refused, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= 16'h0000;
      end else if (|(in_valid & ~grant) && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_count = stall_q;
`else
   assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_noc_output_port_queue.sv
// tb_noc_output_port_queue
// Bench for noc_output_port_queue at its default parameters
// (5 channels, 8-deep FIFO, 46-bit flits). Define OUTPUT_QUEUE_STALL_CNT_EN
// to include the long saturation run of the stall counter.
module tb_noc_output_port_queue;

  localparam int NUM_IN = 5;
  localparam int DEPTH  = 8;
  localparam int FLIT_W = 46;

  logic                     clk;
  logic                     reset;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_ready;
  logic [3:0]               count;
  logic                     full;
  logic                     empty;
  logic [15:0]              stall_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [FLIT_W-1:0] exp_q[$];
  int m_cnt   = 0;
  int m_rr    = 0;
  int m_stall = 0;
  int seq     = 0;

  noc_output_port_queue dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_flit    (in_flit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .stall_count(stall_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input int n);
    logic [7:0]  dest;
    logic [3:0]  req;
    logic [31:0] data;
    dest = 8'(8'h10 + n);
    req  = 4'(n);
    data = 32'(32'hA0 + n);
    return {dest, req, n[0], ~n[0], data};
  endfunction

  // Expected grants: walk from rr and grant while grants < free.
  task automatic model_grant(input logic [NUM_IN-1:0] v, input int rr, input int cnt,
                             output logic [NUM_IN-1:0] g, output int n, output int nrr);
    int  idx;
    bit  seen;
    g    = '0;
    n    = 0;
    nrr  = rr;
    seen = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (rr + k) % NUM_IN;
      if (v[idx]) begin
        if (n < DEPTH - cnt) begin
          g[idx] = 1'b1;
          n++;
        end else if (!seen) begin
          seen = 1;
          nrr  = idx;
        end
      end
    end
  endtask

  // One clock cycle: check outputs at the falling edge, update the
  // scoreboard, then return just after the next rising edge.
  task automatic cycle();
    logic [NUM_IN-1:0] g;
    int n, nrr, idx, p;
    @(negedge clk);
    if (reset) begin
      chk("rst_in_ready", in_ready, '0);
      m_cnt = 0; m_rr = 0; m_stall = 0;
      exp_q.delete();
    end else begin
      model_grant(in_valid, m_rr, m_cnt, g, n, nrr);
      chk("in_ready", in_ready, g);
      chk("count", count, m_cnt);
      chk("out_valid", out_valid, m_cnt != 0);
      chk("full", full, m_cnt == DEPTH);
      chk("empty", empty, m_cnt == 0);
`ifdef OUTPUT_QUEUE_STALL_CNT_EN
      chk("stall_count", stall_count, m_stall);
`else
      chk("stall_count", stall_count, 0);
`endif
      if (m_cnt == 0) chk("out_flit_empty", out_flit, '0);
      for (int k = 0; k < NUM_IN; k++) begin
        idx = (m_rr + k) % NUM_IN;
        if (g[idx]) exp_q.push_back(in_flit[idx*FLIT_W +: FLIT_W]);
      end
      p = 0;
      if (m_cnt != 0 && out_ready) begin
        p = 1;
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("out_flit", out_flit, exp_q.pop_front());
      end
      if (|(in_valid & ~g) && m_stall != 16'hFFFF) m_stall++;
      m_cnt = m_cnt + n - p;
      m_rr  = nrr;
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic [NUM_IN-1:0] v, input logic ordy);
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < NUM_IN; i++) begin
      in_flit[i*FLIT_W +: FLIT_W] = mk(seq);
      seq++;
    end
  endtask

  task automatic drain();
    drive('0, 1'b1);
    for (int i = 0; i < 2*DEPTH && m_cnt != 0; i++) cycle();
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0;
    in_flit = '0;
    out_ready = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, '0);
    chk("rst_stall", stall_count, 0);

    // 1: all five channels at once into an empty FIFO, then drain in order
    in_valid = '1;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) in_flit[i*FLIT_W +: FLIT_W] = mk(i);
    #1 chk("t1_ready", in_ready, 5'b11111);
    cycle();
    in_valid = '0;
    chk("t1_count", count, 5);
    chk("t1_head", out_flit, mk(0));
    drain();

    // 2: count 6, all valid -> only channels 0,1 fit; full with pop -> no push
    drive('1, 1'b0); cycle();
    drive(5'b00001, 1'b0); cycle();
    chk("t2_count6", count, 6);
    drive('1, 1'b0);
    #1 chk("t2_ready_a", in_ready, 5'b00011);
    cycle();
    chk("t2_count8", count, 8);
    chk("t2_full", full, 1);
    drive('1, 1'b1);
    #1 chk("t2_ready_full", in_ready, 5'b00000);
    cycle();
    chk("t2_count7", count, 7);
    drive('1, 1'b0);
    #1 chk("t2_ready_ch2", in_ready, 5'b00100);
    cycle();
    drain();

    // 3: channel 3 streams 20 flits with continuous drain
    for (int i = 0; i < 20; i++) begin
      drive(5'b01000, 1'b1);
      cycle();
      chk("t3_cnt_le1", count <= 1, 1);
    end
    drain();

    // 4: full FIFO, pop and channel 3 request in the same cycle
    for (int i = 0; i < 4 && m_cnt < DEPTH; i++) begin
      drive('1, 1'b0);
      cycle();
    end
    chk("t4_full", full, 1);
    drive(5'b01000, 1'b1);
    #1 chk("t4_ready_blocked", in_ready[3], 0);
    cycle();
    chk("t4_count7", count, 7);
    #1 chk("t4_ready_open", in_ready[3], 1);
    cycle();
    drain();

    // 5: reset mid-operation discards contents
    drive(5'b01111, 1'b0); cycle();
    chk("t5_count4", count, 4);
    drive(5'b10001, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_count0", count, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_flit", out_flit, '0);
    drive('0, 1'b0); cycle();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive(NUM_IN'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      cycle();
    end
    drain();

    // 6: full FIFO with channel 1 refused for a long time
    for (int i = 0; i < 4 && m_cnt < DEPTH; i++) begin
      drive('1, 1'b0);
      cycle();
    end
    drive(5'b00010, 1'b0);
`ifdef OUTPUT_QUEUE_STALL_CNT_EN
    for (int i = 0; i < 70000; i++) cycle();
    chk("t6_stall_sat", stall_count, 16'hFFFF);
    cycle();
    chk("t6_stall_hold", stall_count, 16'hFFFF);
`else
    for (int i = 0; i < 50; i++) cycle();
    chk("t6_stall_zero", stall_count, 16'h0000);
`endif
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_stall_clr", stall_count, 16'h0000);
    chk("t6_count_clr", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
